// File: rtl/mantle_split_pkg.sv
// Shared types, defaults and width helper for the mantle_split_stream frame deserializer.
package mantle_split_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N1    = 9;
    localparam int DEF_N2    = 6;

    // Index width for a frame of n words; never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mantle_split_ctr.sv
// Frame word index: clears on clr, advances on inc and wraps to zero after the last word.
module mantle_split_ctr
    import mantle_split_pkg::*;
#(
    parameter  int LEN = DEF_N1 + DEF_N2,
    localparam int IW  = idx_w(LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [IW-1:0] idx,
    output logic          last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    assign idx  = idx_q;
    assign last = (idx_q == LAST_IDX);

    // NOTE: every always_comb target is given a default first, so no path can infer a latch.
    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/mantle_split_stream.sv
// Serial-to-array deserializer: collects N1+N2 words per frame and presents them as two
// registered arrays under a valid/ready handshake, overlapping the next frame's first word.
module mantle_split_stream
    import mantle_split_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N1    = DEF_N1,
    parameter  int N2    = DEF_N2,
    localparam int LEN   = N1 + N2,
    localparam int IW    = idx_w(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1 [N1],
    output logic [WIDTH-1:0] out2 [N2],
    output logic [IW-1:0]    idx
);

    generate
        if (N1 < 1 || N2 < 1 || WIDTH < 1) begin : g_bad_params
            $error("mantle_split_stream: N1, N2 and WIDTH must all be at least 1");
        end
    endgenerate

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] out1_q [N1];
    logic [WIDTH-1:0] out1_d [N1];
    logic [WIDTH-1:0] out2_q [N2];
    logic [WIDTH-1:0] out2_d [N2];
    logic [IW-1:0]    idx_q;
    logic             last;
    logic             in_xfer;
    logic             drop;
    logic             wr_en;

    // A held frame may only be released by the consumer, so input readiness follows out_ready.
    assign in_ready  = (state_q == FILL) || out_ready;
    assign out_valid = (state_q == FULL);
    assign in_xfer   = in_valid && in_ready;
    assign drop      = flush && (state_q == FILL);
    assign wr_en     = in_xfer && !drop;

    mantle_split_ctr #(
        .LEN (LEN)
    ) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .clr  (drop),
        .inc  (wr_en),
        .idx  (idx_q),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (wr_en && last) state_d = FULL;
            FULL: if (out_ready) state_d = (wr_en && last) ? FULL : FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        out1_d = out1_q;
        out2_d = out2_q;
        for (int k = 0; k < N1; k++) begin
            if (wr_en && idx_q == IW'(k)) out1_d[k] = in_data;
        end
        for (int j = 0; j < N2; j++) begin
            if (wr_en && idx_q == IW'(N1 + j)) out2_d[j] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            // NOTE: the arrays are output ports with defined reset contents, so they take rst like any other flop.
            for (int k = 0; k < N1; k++) out1_q[k] <= '0;
            for (int j = 0; j < N2; j++) out2_q[j] <= '0;
        end else begin
            state_q <= state_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
        end
    end

    assign out1 = out1_q;
    assign out2 = out2_q;
    assign idx  = idx_q;

endmodule

// File: tb/tb_mantle_split_stream.sv
// Bench for mantle_split_stream: a 9+6 instance and a 1+1 instance, checked by a frame-level
// reference model feeding a scoreboard, with directed scenarios followed by random traffic.
module tb_mantle_split_stream;

    logic        clk = 1'b0;
    logic [1:0]  rst_v;
    logic [1:0]  flush_v;
    logic [1:0]  in_valid_v;
    logic [1:0]  out_ready_v;
    logic [31:0] in_data_v [2];

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out1_a [9];
    logic [31:0] out2_a [6];
    logic [31:0] out1_b [1];
    logic [31:0] out2_b [1];
    logic [3:0]  idx_a;
    logic [0:0]  idx_b;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] acc_q [2][$];
    logic [31:0] sb_q  [2][$];
    bit          full_m [2];

    always #5 clk = ~clk;

    mantle_split_stream #(.WIDTH(32), .N1(9), .N2(6)) u_dut_a (
        .clk(clk), .rst(rst_v[0]), .flush(flush_v[0]),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_a), .in_data(in_data_v[0]),
        .out_valid(out_valid_a), .out_ready(out_ready_v[0]),
        .out1(out1_a), .out2(out2_a), .idx(idx_a)
    );

    mantle_split_stream #(.WIDTH(32), .N1(1), .N2(1)) u_dut_b (
        .clk(clk), .rst(rst_v[1]), .flush(flush_v[1]),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_b), .in_data(in_data_v[1]),
        .out_valid(out_valid_b), .out_ready(out_ready_v[1]),
        .out1(out1_b), .out2(out2_b), .idx(idx_b)
    );

    function automatic int len_of(input int i);
        return (i == 0) ? 15 : 2;
    endfunction

    function automatic logic [31:0] get_word(input int i, input int k);
        if (i == 0) begin
            if (k < 9) return out1_a[k];
            return out2_a[k-9];
        end
        if (k == 0) return out1_b[0];
        return out2_b[0];
    endfunction

    function automatic logic [31:0] get_in_ready(input int i);
        return {31'b0, (i == 0) ? in_ready_a : in_ready_b};
    endfunction

    function automatic logic [31:0] get_out_valid(input int i);
        return {31'b0, (i == 0) ? out_valid_a : out_valid_b};
    endfunction

    function automatic logic [31:0] get_idx(input int i);
        return (i == 0) ? {28'b0, idx_a} : {31'b0, idx_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Frame-level model: words accepted are gathered; a full frame goes to the scoreboard.
    task automatic model_step(input int i);
        bit exp_rdy;
        bit was_full;
        if (rst_v[i]) begin
            acc_q[i].delete();
            sb_q[i].delete();
            full_m[i] = 1'b0;
            return;
        end
        exp_rdy = !full_m[i] || out_ready_v[i];
        check($sformatf("in_ready[%0d]", i), get_in_ready(i), {31'b0, exp_rdy});
        check($sformatf("out_valid[%0d]", i), get_out_valid(i), {31'b0, full_m[i]});
        check($sformatf("idx[%0d]", i), get_idx(i), acc_q[i].size());
        was_full = full_m[i];
        if (was_full && out_ready_v[i]) full_m[i] = 1'b0;
        if (flush_v[i] && !was_full) begin
            acc_q[i].delete();
        end else if (in_valid_v[i] && exp_rdy) begin
            acc_q[i].push_back(in_data_v[i]);
            if (acc_q[i].size() == len_of(i)) begin
                for (int k = 0; k < len_of(i); k++) sb_q[i].push_back(acc_q[i][k]);
                acc_q[i].delete();
                full_m[i] = 1'b1;
            end
        end
    endtask

    task automatic monitor_step(input int i);
        if (rst_v[i] || get_out_valid(i) != 32'd1) return;
        if (sb_q[i].size() < len_of(i)) begin
            check($sformatf("frame_expected[%0d]", i), 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < len_of(i); k++)
            check($sformatf("word[%0d][%0d]", i, k), get_word(i, k), sb_q[i][k]);
        if (out_ready_v[i]) repeat (len_of(i)) void'(sb_q[i].pop_front());
    endtask

    always @(negedge clk) for (int i = 0; i < 2; i++) model_step(i);
    always @(negedge clk) for (int i = 0; i < 2; i++) monitor_step(i);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input bit v, input logic [31:0] d, input bit ordy, input bit fl);
        in_valid_v[i]  = v;
        in_data_v[i]   = d;
        out_ready_v[i] = ordy;
        flush_v[i]     = fl;
    endtask

    task automatic check_reset(input int i, input string tag);
        check({tag, "_in_ready"}, get_in_ready(i), 32'd1);
        check({tag, "_out_valid"}, get_out_valid(i), 32'd0);
        check({tag, "_idx"}, get_idx(i), 32'd0);
        for (int k = 0; k < len_of(i); k++)
            check($sformatf("%s_word%0d", tag, k), get_word(i, k), 32'd0);
    endtask

    initial begin
        rst_v = 2'b11;
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        set_in(1, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        check_reset(0, "reset_a");
        check_reset(1, "reset_b");
        rst_v = 2'b00;

        // Single frame, then the 1+1 variant.
        for (int k = 0; k < 15; k++) begin
            set_in(0, 1'b1, 32'h100 + k, 1'b1, 1'b0);
            tick();
        end
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("s2_out_valid", {31'b0, out_valid_a}, 32'd1);
        for (int k = 0; k < 9; k++) check($sformatf("s2_out1_%0d", k), out1_a[k], 32'h100 + k);
        for (int j = 0; j < 6; j++) check($sformatf("s2_out2_%0d", j), out2_a[j], 32'h109 + j);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_in(1, 1'b1, 32'h100 + k, 1'b1, 1'b0);
            tick();
        end
        set_in(1, 1'b0, 32'd0, 1'b1, 1'b0);
        check("s2b_out_valid", {31'b0, out_valid_b}, 32'd1);
        check("s2b_out1_0", out1_b[0], 32'h100);
        check("s2b_out2_0", out2_b[0], 32'h101);
        tick();

        // Back-to-back frames with no bubble.
        for (int k = 0; k < 30; k++) begin
            set_in(0, 1'b1, 32'h200 + k, 1'b1, 1'b0);
            tick();
            if (k == 15) check("s3_idx_after_boundary", {28'b0, idx_a}, 32'd1);
        end
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("s3_second_out1_0", out1_a[0], 32'h20F);
        tick();

        // Consumer stall for five cycles.
        for (int k = 0; k < 15; k++) begin
            set_in(0, 1'b1, 32'h300 + k, 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            set_in(0, 1'b1, 32'hDEAD_0000 + c, 1'b0, 1'b0);
            tick();
            check("s4_stall_in_ready", {31'b0, in_ready_a}, 32'd0);
            check("s4_stall_out1_0", out1_a[0], 32'h300);
        end
        set_in(0, 1'b1, 32'h400, 1'b1, 1'b0);
        tick();
        check("s4_release_idx", {28'b0, idx_a}, 32'd1);
        check("s4_release_out1_0", out1_a[0], 32'h400);
        for (int k = 1; k < 15; k++) begin
            set_in(0, 1'b1, 32'h400 + k, 1'b1, 1'b0);
            tick();
        end
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        tick();

        // Flush mid-frame drops the same-cycle word.
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1'b1, 32'h500 + k, 1'b1, 1'b0);
            tick();
        end
        set_in(0, 1'b1, 32'h0BAD, 1'b1, 1'b1);
        tick();
        check("s5_flush_idx", {28'b0, idx_a}, 32'd0);
        for (int k = 0; k < 15; k++) begin
            set_in(0, 1'b1, 32'h600 + k, 1'b1, 1'b0);
            tick();
        end
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        check("s5_out1_0", out1_a[0], 32'h600);
        check("s5_out1_4", out1_a[4], 32'h604);
        tick();

        // Reset while holding a frame, then reset mid-frame.
        for (int k = 0; k < 15; k++) begin
            set_in(0, 1'b1, 32'h700 + k, 1'b0, 1'b0);
            tick();
        end
        set_in(0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        rst_v[0] = 1'b1;
        tick();
        check_reset(0, "s6_full");
        rst_v[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_in(0, 1'b1, 32'h800 + k, 1'b1, 1'b0);
            tick();
        end
        rst_v[0] = 1'b1;
        tick();
        check_reset(0, "s6_partial");
        rst_v[0] = 1'b0;

        // Random traffic on both instances.
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                set_in(i, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 40) == 0);
                rst_v[i] = ($urandom_range(0, 400) == 0);
            end
            tick();
        end

        rst_v = 2'b00;
        set_in(0, 1'b0, 32'd0, 1'b1, 1'b0);
        set_in(1, 1'b0, 32'd0, 1'b1, 1'b0);
        repeat (5) tick();
        check("drain_a", sb_q[0].size(), 32'd0);
        check("drain_b", sb_q[1].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
